// File: rtl/permission_controller.sv
// Access-control unit: user/function requests are checked against a runtime
// programmable permission table; repeated denials trigger a timed lockout.
module permission_controller #(
  parameter int USER_W      = 3,
  parameter int FUNC_W      = 3,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_we,
  input  logic [USER_W-1:0]                cfg_user,
  input  logic [FUNC_W-1:0]                cfg_func,
  input  logic                             cfg_allow,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [USER_W-1:0]                req_user,
  input  logic [FUNC_W-1:0]                req_func,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [FUNC_W-1:0]                rsp_func,
  output logic                             rsp_grant,
  output logic                             locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

  localparam int NU  = 2 ** USER_W;
  localparam int NF  = 2 ** FUNC_W;
  localparam int FCW = $clog2(MAX_FAILS + 1);
  localparam int TW  = $clog2(LOCK_CYCLES + 1);
  localparam logic [FCW-1:0] MAXF = FCW'(MAX_FAILS);
  localparam logic [TW-1:0]  LC   = TW'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_RESP,
    S_LOCKED
  } state_e;

  state_e                     state_q;
  logic [NU-1:0][NF-1:0]      tbl_q;
  logic [USER_W-1:0]          user_q;
  logic [FUNC_W-1:0]          func_q;
  logic [TW-1:0]              timer_q;
  logic [FCW-1:0]             fail_q;
  logic                       ready_q;
  logic                       rsp_valid_q;
  logic                       rsp_grant_q;
  logic [FUNC_W-1:0]          rsp_func_q;
  logic                       locked_q;
  logic                       allow;

  // Lookup sees the table as it was before the CHECK edge.
  assign allow = tbl_q[user_q][func_q] & (func_q != '0);

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_grant = rsp_grant_q;
  assign rsp_func  = rsp_func_q;
  assign locked    = locked_q;
  assign fail_cnt  = fail_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q <= '0;
    end else if (cfg_we) begin
      tbl_q[cfg_user][cfg_func] <= cfg_allow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      user_q      <= '0;
      func_q      <= '0;
      timer_q     <= '0;
      fail_q      <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_grant_q <= 1'b0;
      rsp_func_q  <= '0;
      locked_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (req_valid && ready_q) begin
            user_q  <= req_user;
            func_q  <= req_func;
            ready_q <= 1'b0;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          rsp_valid_q <= 1'b1;
          rsp_grant_q <= allow;
          rsp_func_q  <= allow ? func_q : '0;
          if (allow) begin
            fail_q <= '0;
          end else if (fail_q != MAXF) begin
            fail_q <= fail_q + FCW'(1);
          end
          state_q <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (fail_q == MAXF) begin
              locked_q <= 1'b1;
              timer_q  <= LC;
              state_q  <= S_LOCKED;
            end else begin
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        S_LOCKED: begin
          // Exit on the edge that completes the LOCK_CYCLES-th locked cycle.
          if (timer_q <= TW'(1)) begin
            timer_q  <= '0;
            fail_q   <= '0;
            locked_q <= 1'b0;
            ready_q  <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
